seq_shifter: RTL and testbench

//   Iterative RV32I shift unit for SLL/SRL/SRA (and SLLI/SRLI/SRAI), one bit per cycle.

---
 rtl/seq_shifter.sv | 133 +++++++++++++
 tb/tb_seq_shifter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// ---------------------------------------------------------------------------
// seq_shifter
//   Iterative RV32I shift unit (SLL/SRL/SRA and immediate forms). It moves
//   the operand one bit per cycle. This is a small alternative to a full
//   barrel shifter and sits beside the ALU in the execute stage.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   flush      synchronous pipeline flush; abandons any operation in flight
//   in_valid   request valid
//   in_ready   unit can accept a request this cycle
//   op         op[0]: 0=left, 1=right; op[1]: arithmetic (right shifts only)
//   operand    value to shift (rs1)
//   shamt      shift amount, 0..XLEN-1
//   out_valid  result valid
//   out_ready  consumer takes the result this cycle
//   result     shifted value (meaningful only while out_valid is high)
//   busy       unit is not idle
// ---------------------------------------------------------------------------
module seq_shifter #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] operand,
    input  logic [SHW-1:0]  shamt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] data_q,  data_d;
    logic [SHW-1:0]  cnt_q,   cnt_d;
    logic            dir_q,   dir_d;
    logic            arith_q, arith_d;
    logic            sign_q,  sign_d;

    logic            accept;
    logic            fill;

    // in_ready is gated by rst so that no request is taken while reset is held.
    assign in_ready  = (state_q == ST_IDLE) & ~rst;
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign result    = data_q;

    // Bit shifted in at the top on right shifts: the captured sign for SRA, zero for SRL.
    assign fill = arith_q & sign_q;

    // Next-state logic. Flush overrides everything else, including a pending
    // accept and a handshake on the output.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        arith_d = arith_q;
        sign_d  = sign_q;

        if (flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        data_d  = operand;
                        cnt_d   = shamt;
                        dir_d   = op[0];
                        // Arithmetic mode only applies to right shifts; op=2'b10 is a plain SLL.
                        arith_d = op[1] & op[0];
                        sign_d  = operand[XLEN-1];
                        state_d = (shamt == '0) ? ST_DONE : ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // The count check keeps cnt_q from wrapping even if SHIFT were entered with zero.
                    if (cnt_q != '0) begin
                        if (dir_q) begin
                            data_d = {fill, data_q[XLEN-1:1]};
                        end else begin
                            data_d = {data_q[XLEN-2:0], 1'b0};
                        end
                        cnt_d = cnt_q - SHW'(1);
                    end
                    if (cnt_q <= SHW'(1)) begin
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            arith_q <= 1'b0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            arith_q <= arith_d;
            sign_q  <= sign_d;
        end
    end

endmodule

// File: tb/tb_seq_shifter.sv
// ---------------------------------------------------------------------------
// tb_seq_shifter
//   Scoreboard bench for seq_shifter. The driver issues requests and pushes
//   the expected word and acceptance cycle. An independent monitor compares
//   each presented result and its latency against that queue.
// ---------------------------------------------------------------------------
module tb_seq_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] operand;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          sh;
    } expT;

    expT expQ[$];
    int  cyc = 0;
    int  checks = 0;
    int  errors = 0;

    seq_shifter #(.XLEN(32), .SHW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand   (operand),
        .shamt     (shamt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference behaviour written directly from the RV32I shift semantics.
    function automatic logic [31:0] refShift(input logic [1:0] o, input logic [31:0] v,
                                             input logic [4:0] s);
        if (!o[0]) return v << s;
        else if (o[1]) return 32'($signed(v) >>> s);
        else return v >> s;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drives one request and waits for acceptance. Returns at posedge+1 after the accept edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] v, input logic [4:0] s,
                         input bit doPush);
        int  w;
        expT e;
        in_valid = 1'b1;
        op       = o;
        operand  = v;
        shamt    = s;
        w        = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            checkOutput("acceptTimeout", 32'(in_ready), 32'd1);
        end else if (doPush) begin
            e.res = refShift(o, v, s);
            e.acc = cyc;
            e.sh  = int'(s);
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Full transaction: out_ready is held low for 'delay' cycles once the result appears.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] v, input logic [4:0] s,
                                 input int delay);
        int w;
        out_ready = (delay == 0);
        issue(o, v, s, 1'b1);
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!out_valid) begin
            checkOutput("resultTimeout", 32'(out_valid), 32'd1);
            return;
        end
        repeat (delay) @(posedge clk);
        if (delay > 0) begin
            #1;
            out_ready = 1'b1;
        end
        @(posedge clk);
        #1;
        checkOutput("idleOutValid", 32'(out_valid), 32'd0);
        checkOutput("idleInReady", 32'(in_ready), 32'd1);
    endtask

    // Monitor: compares every presented result with the head of the scoreboard.
    initial begin : monitor
        bit prevValid;
        expT e;
        prevValid = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevValid = 1'b0;
            end else begin
                if (out_valid) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpectedOutValid", 32'(out_valid), 32'd0);
                    end else begin
                        e = expQ[0];
                        checkOutput("result", result, e.res);
                        checkOutput("inReadyInDone", 32'(in_ready), 32'd0);
                        checkOutput("busyInDone", 32'(busy), 32'd1);
                        if (!prevValid) begin
                            checkOutput("latency", 32'(cyc - e.acc), 32'(1 + e.sh));
                        end
                        if (out_ready) void'(expQ.pop_front());
                    end
                end
                prevValid = out_valid;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : stimulus
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        op        = 2'b00;
        operand   = '0;
        shamt     = '0;
        out_ready = 1'b0;
        #1;
        checkOutput("rstInReady", 32'(in_ready), 32'd0);
        checkOutput("rstOutValid", 32'(out_valid), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstResult", result, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("releaseInReady", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed cases: max shift, arithmetic vs logical, zero shift, backpressure.
        applyStimulus(2'b00, 32'h0000_0001, 5'd31, 0);
        applyStimulus(2'b11, 32'h8000_0000, 5'd4, 0);
        applyStimulus(2'b01, 32'h8000_0000, 5'd4, 0);
        applyStimulus(2'b11, 32'hDEAD_BEEF, 5'd0, 0);
        applyStimulus(2'b10, 32'hF000_000F, 5'd4, 0);
        applyStimulus(2'b11, 32'h8765_4321, 5'd7, 3);

        // Flush mid-shift: the abandoned request must never produce a result.
        out_ready = 1'b1;
        issue(2'b00, 32'h0000_0001, 5'd10, 1'b0);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flushBusy", 32'(busy), 32'd0);
        checkOutput("flushInReady", 32'(in_ready), 32'd1);
        repeat (15) @(posedge clk);
        #1;
        applyStimulus(2'b00, 32'h0000_0001, 5'd3, 0);

        // Flush while a result waits in DONE drops that result.
        out_ready = 1'b0;
        applyStimulus(2'b01, 32'hFFFF_0000, 5'd2, 100);
        // The call above times out deliberately? No: handled separately below.
        out_ready = 1'b0;
        issue(2'b01, 32'h0000_FF00, 5'd0, 1'b1);
        @(negedge clk);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        void'(expQ.pop_front());
        checkOutput("flushDoneOutValid", 32'(out_valid), 32'd0);
        checkOutput("flushDoneBusy", 32'(busy), 32'd0);

        // Reset in the middle of a shift.
        out_ready = 1'b1;
        issue(2'b00, 32'h1234_5678, 5'd20, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("midRstOutValid", 32'(out_valid), 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstInReady", 32'(in_ready), 32'd0);
        checkOutput("midRstResult", result, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        applyStimulus(2'b00, 32'h0000_0003, 5'd1, 0);
        applyStimulus(2'b01, 32'h0000_0F00, 5'd5, 0);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 40; i++) begin
            applyStimulus(2'($urandom_range(3, 0)), $urandom, 5'($urandom_range(31, 0)),
                          int'($urandom_range(3, 0)));
        end

        repeat (3) @(posedge clk);
        checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
